// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: result lands WIDTH edges after the accept edge, with a one-cycle done pulse.
// start is only honoured while idle; busy=1 means a request would be ignored.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             ai, bi, d_bit, br_next;
    logic [WIDTH-1:0] res_shift;

    // Single full-subtractor cell fed from the operand LSBs.
    always_comb begin
        ai        = op_a_q[0];
        bi        = op_b_q[0];
        d_bit     = ai ^ bi ^ br_q;
        br_next   = (~ai & bi) | (~(ai ^ bi) & br_q);
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = d_bit;
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        br_d         = br_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                // Outputs only change here, so partial results never escape.
                if (cnt_q == LAST) begin
                    diff_d       = res_shift;
                    borrow_out_d = br_next;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            br_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            br_q         <= br_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] a, b, diff;
    logic       busy, done, borrow_out;

    logic       rst1, start1;
    logic [0:0] a1, b1, diff1;
    logic       busy1, done1, borrow1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until done; also counts samples with busy low before done.
    task automatic wait_done(output int cyc, output int busy_low);
        cyc = 0;
        busy_low = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && !busy) busy_low++;
        end while (!done && cyc < 40);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int cyc, bl;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc, bl);
        check({tag, "_lat"}, cyc + 1, 9);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, borrow_out, eb);
        check({tag, "_busylow"}, bl, 0);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int cyc, bl;
        logic [1:0] ab;
        logic [1:0] exp1 [4];
        exp1[0] = 2'b00; exp1[1] = 2'b11; exp1[2] = 2'b10; exp1[3] = 2'b00;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst1 = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", borrow_out, 0);
        check("rst1_busy", busy1, 0);

        run_op("s5a_23", 8'h5A, 8'h23, 8'h37, 1'b0);
        run_op("s00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("sff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("s80_7f", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        check("ign_diff_hold", diff, 8'h01);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", busy, 1);
        wait_done(cyc, bl);
        check("ign_lat", cyc, 5);
        check("ign_diff", diff, 8'h0F);
        check("ign_bout", borrow_out, 0);
        check("ign_busylow", bl, 0);
        @(negedge clk);
        check("ign_done_once", done, 0);
        check("ign_idle", busy, 0);

        // Reset in the middle of RUN.
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", borrow_out, 0);
        bl = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) bl++;
        end
        check("abort_quiet", bl, 0);
        run_op("s02_03", 8'h02, 8'h03, 8'hFF, 1'b1);

        // Continuous start: one result every 9 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h09; b = 8'h04;
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc, bl);
            check($sformatf("hold%0d_lat", k), cyc, 9);
            check($sformatf("hold%0d_diff", k), diff, 8'h05);
            check($sformatf("hold%0d_bout", k), borrow_out, 0);
            check($sformatf("hold%0d_busy", k), busy, 0);
            check($sformatf("hold%0d_busylow", k), bl, 0);
        end
        start = 1'b0;
        @(negedge clk);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            start1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("w1_%0d_busy", i), busy1, 1);
            check($sformatf("w1_%0d_early", i), done1, 0);
            @(negedge clk);
            check($sformatf("w1_%0d_done", i), done1, 1);
            check($sformatf("w1_%0d_diff", i), diff1, exp1[i][1]);
            check($sformatf("w1_%0d_bout", i), borrow1, exp1[i][0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
